calc_seq_ctrl: RTL
==================

Name: calc_seq_ctrl

Overview:
Sequencer for the PS/2 calculator. It consumes decoded key events from the keyboard front end and accumulates decimal operands A and B and an operator. It starts a multi-cycle ALU, waits for its completion, and presents the result or an error for display. It sits between the PS/2 key decoder and the arithmetic unit and owns all calculator state.

Parameters:
MAX_DIGITS, 4, maximum decimal digits per operand; further digits are dropped.
OP_W, 14, operand width in bits (9999 fits).
RES_W, 32, ALU result width, two's complement.
TIMEOUT, 1024, cycles allowed in WAIT before the error path.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
key_valid  in  1  key event present
key_code  in  4  0-9 digit, A '+', B '-', C '*', D '/', E enter, F clear
key_ready  out  1  sequencer can accept a key this cycle
alu_start  out  1  one-cycle start pulse
alu_op  out  2  0 add, 1 sub, 2 mul, 3 div; stable from start until done
alu_a  out  OP_W  operand A; stable from start until done
alu_b  out  OP_W  operand B; stable from start until done
alu_done  in  1  one-cycle completion pulse
alu_result  in  RES_W  valid when alu_done=1
disp_value  out  RES_W  value to display
result_valid  out  1  disp_value holds a finished result
busy  out  1  high in EXEC and WAIT
error  out  1  high in ERR

Behaviour:
- Reset: state OPA. A, B and op cleared. Digit count 0. All outputs 0 except key_ready=1. rst beats every other event in the same cycle.
- Handshake: a key is accepted when key_valid && key_ready. key_ready=1 in OPA, OPB, SHOW and ERR, and 0 in EXEC and WAIT. The upstream block holds key_code until accepted.
- Digit accumulation: acc <= acc*10 + digit while count < MAX_DIGITS, then count++. Digits past MAX_DIGITS are accepted and dropped. Leading zeros count as digits.
- OPA:
  - digit -> accumulate into A.
  - operator -> latch op, clear B and count, go to OPB. With no digits entered, A=0.
  - enter -> disp_value = zero-extended A, go to SHOW with no ALU activity.
  - clear -> zero A and count, stay in OPA.
- OPB:
  - digit -> accumulate into B.
  - operator -> replaces op only while B has no digits; otherwise ignored.
  - enter with op=div and B=0 -> ERR, no alu_start.
  - any other enter -> EXEC.
  - clear -> OPA, all cleared.
- EXEC: drive alu_start=1 for exactly one cycle, go to WAIT next cycle, and reset the timeout counter.
- WAIT:
  - alu_done -> capture alu_result into disp_value, go to SHOW next cycle.
  - counter reaches TIMEOUT with no done -> ERR.
  - alu_done arriving in the same cycle as timeout expiry counts as done.
  - alu_done outside WAIT is ignored.
- SHOW: result_valid=1 and disp_value is held.
  - digit -> A=digit, count=1, go to OPA.
  - operator -> chain: if 0 <= result <= 9999 then A=result[OP_W-1:0], latch op, go to OPB; else ERR.
  - enter -> ignored.
  - clear -> OPA.
- ERR: error=1, disp_value=0. Only clear leaves, going to OPA; all other keys are accepted and dropped.
- disp_value in OPA/OPB: zero-extended accumulator currently being entered (A in OPA, B in OPB, 0 right after an operator).
- result_valid: cleared on leaving SHOW.
- busy: combinational from state.
- All other outputs are registered.
- Latency: enter accepted at cycle N gives alu_start at N+1. alu_done at cycle M gives result_valid at M+1.

Test Plan:
- Reset, then keys 1,2,'+',3,4,enter; ALU model returns 46 after 5 cycles -> alu_a=12, alu_b=34, alu_op=0, a single alu_start pulse, disp_value=46, result_valid=1.
- Keys 9,8,7,6,5 -> fifth digit dropped, disp_value=9876. Then '/',0,enter -> error=1, no alu_start. Then clear -> state OPA, disp_value=0.
- Key_valid held high with '7' during WAIT -> key_ready=0, key not consumed until SHOW. It is then taken as a new A=7 and result_valid drops.
- ALU model never asserts done -> error=1 exactly TIMEOUT cycles after WAIT entry. A later stray alu_done is ignored.
- Chaining: 5,'*',6,enter (result 30), then '-',1,enter with result 29 -> alu_a=30, alu_op=1. A '+' on a result of -3 or 12000 -> error=1.
- rst asserted during WAIT while alu_done is high -> all outputs at reset values next cycle, alu_result discarded.

Source files
------------

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencer: collects decimal operands and an operator from key events,
// runs a multi-cycle ALU with a timeout, and drives the display value and status flags.
module calc_seq_ctrl #(
    parameter int MAX_DIGITS = 4,
    parameter int OP_W       = 14,
    parameter int RES_W      = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic             key_ready,
    output logic             alu_start,
    output logic [1:0]       alu_op,
    output logic [OP_W-1:0]  alu_a,
    output logic [OP_W-1:0]  alu_b,
    input  logic             alu_done,
    input  logic [RES_W-1:0] alu_result,
    output logic [RES_W-1:0] disp_value,
    output logic             result_valid,
    output logic             busy,
    output logic             error
);
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [RES_W-1:0] CHAIN_MAX = RES_W'(9999);

    typedef enum logic [2:0] {S_OPA, S_OPB, S_EXEC, S_WAIT, S_SHOW, S_ERR} state_t;

    state_t            state, state_nxt;
    logic [OP_W-1:0]   a_q, a_nxt, b_q, b_nxt;
    logic [1:0]        op_q, op_nxt, key_op;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;
    logic [TMO_W-1:0]  tmo_q;
    logic [RES_W-1:0]  disp_nxt;
    logic              take, is_digit, is_oper, is_enter, is_clear;
    logic              timeout_hit, chain_ok, room;

    function automatic logic [OP_W-1:0] accum(input logic [OP_W-1:0] acc, input logic [3:0] d);
        return acc * OP_W'(10) + OP_W'(d);
    endfunction

    assign take        = key_valid && key_ready;
    assign is_digit    = key_code <= 4'd9;
    assign is_oper     = (key_code >= 4'hA) && (key_code <= 4'hD);
    assign is_enter    = key_code == 4'hE;
    assign is_clear    = key_code == 4'hF;
    assign key_op      = key_code[1:0] + 2'd2;
    assign room        = cnt_q < CNT_W'(MAX_DIGITS);
    assign timeout_hit = tmo_q == TMO_W'(TIMEOUT - 1);
    // Chaining reuses the shown result as operand A, so it must be a non-negative 4-digit value.
    assign chain_ok    = !disp_value[RES_W-1] && (disp_value <= CHAIN_MAX);

    assign busy  = (state == S_EXEC) || (state == S_WAIT);
    assign alu_a = a_q;
    assign alu_b = b_q;
    assign alu_op = op_q;

    always_ff @(posedge clk) begin
        if (rst) state <= S_OPA;
        else     state <= state_nxt;
    end

    // NOTE: every always_comb assigns all its outputs first, so no latches can be inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_OPA: if (take) begin
                if (is_oper)       state_nxt = S_OPB;
                else if (is_enter) state_nxt = S_SHOW;
            end
            S_OPB: if (take) begin
                if (is_enter)      state_nxt = (op_q == 2'd3 && b_q == '0) ? S_ERR : S_EXEC;
                else if (is_clear) state_nxt = S_OPA;
            end
            S_EXEC: state_nxt = S_WAIT;
            S_WAIT: begin
                if (alu_done)         state_nxt = S_SHOW;
                else if (timeout_hit) state_nxt = S_ERR;
            end
            S_SHOW: if (take) begin
                if (is_digit || is_clear) state_nxt = S_OPA;
                else if (is_oper)         state_nxt = chain_ok ? S_OPB : S_ERR;
            end
            S_ERR: if (take && is_clear) state_nxt = S_OPA;
            default: state_nxt = S_OPA;
        endcase
    end

    always_comb begin
        a_nxt   = a_q;
        b_nxt   = b_q;
        op_nxt  = op_q;
        cnt_nxt = cnt_q;
        if (take) begin
            case (state)
                S_OPA: begin
                    if (is_digit && room) begin
                        a_nxt   = accum(a_q, key_code);
                        cnt_nxt = cnt_q + CNT_W'(1);
                    end else if (is_oper) begin
                        op_nxt  = key_op;
                        b_nxt   = '0;
                        cnt_nxt = '0;
                    end else if (is_clear) begin
                        a_nxt   = '0;
                        cnt_nxt = '0;
                    end
                end
                S_OPB: begin
                    if (is_digit && room) begin
                        b_nxt   = accum(b_q, key_code);
                        cnt_nxt = cnt_q + CNT_W'(1);
                    end else if (is_oper && cnt_q == '0) begin
                        op_nxt = key_op;
                    end else if (is_clear) begin
                        a_nxt = '0; b_nxt = '0; op_nxt = '0; cnt_nxt = '0;
                    end
                end
                S_SHOW: begin
                    if (is_digit) begin
                        a_nxt   = OP_W'(key_code);
                        cnt_nxt = CNT_W'(1);
                    end else if (is_oper && chain_ok) begin
                        a_nxt   = disp_value[OP_W-1:0];
                        op_nxt  = key_op;
                        b_nxt   = '0;
                        cnt_nxt = '0;
                    end else if (is_clear) begin
                        a_nxt = '0; b_nxt = '0; op_nxt = '0; cnt_nxt = '0;
                    end
                end
                S_ERR: if (is_clear) begin
                    a_nxt = '0; b_nxt = '0; op_nxt = '0; cnt_nxt = '0;
                end
                default: ;
            endcase
        end
    end

    // Display follows the operand being typed, the captured result, or zero on error.
    always_comb begin
        disp_nxt = disp_value;
        case (state_nxt)
            S_OPA:  disp_nxt = RES_W'(a_nxt);
            S_OPB:  disp_nxt = RES_W'(b_nxt);
            S_SHOW: begin
                if (state == S_WAIT)     disp_nxt = alu_result;
                else if (state == S_OPA) disp_nxt = RES_W'(a_q);
            end
            S_ERR:  disp_nxt = '0;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            cnt_q        <= '0;
            tmo_q        <= '0;
            disp_value   <= '0;
            key_ready    <= 1'b1;
            alu_start    <= 1'b0;
            result_valid <= 1'b0;
            error        <= 1'b0;
        end else begin
            a_q          <= a_nxt;
            b_q          <= b_nxt;
            op_q         <= op_nxt;
            cnt_q        <= cnt_nxt;
            tmo_q        <= (state == S_WAIT) ? tmo_q + TMO_W'(1) : '0;
            disp_value   <= disp_nxt;
            key_ready    <= !((state_nxt == S_EXEC) || (state_nxt == S_WAIT));
            alu_start    <= state_nxt == S_EXEC;
            result_valid <= state_nxt == S_SHOW;
            error        <= state_nxt == S_ERR;
        end
    end
endmodule
